// File: rtl/lt24_touch_adc_responder.sv
// lt24_touch_adc_responder
//
// SPI-slave model of the LT24 touch-panel ADC (ADS7843-style). It decodes the
// 8-bit control byte sent by the touch_panel_spi master, raises BUSY for one
// dclk, then returns a 12-bit (or 8-bit) X/Y sample MSB-first. PENIRQ_N follows
// the pen_down input while the converter is idle and PD0 of the last control
// byte is 0.
//
// All SPI inputs are resynchronised to clk, so adc_dclk must be <= clk/8.
// DIN is sampled on a synced dclk rise. DOUT and BUSY change on a synced dclk
// fall, SYNC_STAGES+1 clk after the pin edge.
//
// Handshake: there is no valid/ready pair. A frame is bounded by adc_cs_n low.
// The control byte is valid once its 8th bit has been sampled on a dclk rise.
// Result bits are valid from the dclk fall that drives them until the next fall.
// conv_done marks the clk in which the last result bit is driven.
//
// Optional feature, macro LT24_ADC_ERR_EN: adds frame_err (sticky) and
// err_count (saturating). Both count frames aborted by adc_cs_n rising while the
// FSM is in CMD, WAITB, BUSY or DATA.
//
// Parameters:
//   SYNC_STAGES  flops per input synchronizer (>= 2)
//   DATA_W       full-resolution sample width (>= 8)
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   adc_cs_n         SPI slave select from master (active low)
//   adc_dclk         SPI clock from master (idle low)
//   adc_din          SPI MOSI, carries the control byte
//   adc_dout         SPI MISO, carries the result bits
//   adc_busy         BUSY to master
//   adc_penirq_n     pen interrupt, active low
//   pen_down         emulated touch present
//   x_value/y_value  samples returned for channel 3'b101 / 3'b001
//   conv_done        1-clk pulse when the last result bit is driven
//   last_ctrl        most recent complete control byte
//   frame_err        (LT24_ADC_ERR_EN) sticky aborted-frame flag
//   err_count        (LT24_ADC_ERR_EN) saturating aborted-frame count
module lt24_touch_adc_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_cs_n,
  input  logic              adc_dclk,
  input  logic              adc_din,
  output logic              adc_dout,
  output logic              adc_busy,
  output logic              adc_penirq_n,
  input  logic              pen_down,
  input  logic [DATA_W-1:0] x_value,
  input  logic [DATA_W-1:0] y_value,
  output logic              conv_done,
  output logic [7:0]        last_ctrl
`ifdef LT24_ADC_ERR_EN
  ,
  output logic              frame_err,
  output logic [7:0]        err_count
`endif
);

  // Counter must hold both 7 (control byte) and DATA_W (result bits).
  localparam int CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Bits below the top 8 of a sample; cleared in 8-bit mode.
  localparam logic [DATA_W-1:0] LOW_BITS = {DATA_W{1'b1}} >> 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    CMD   = 3'd2,
    WAITB = 3'd3,
    BUSY  = 3'd4,
    DATA  = 3'd5,
    TAIL  = 3'd6
  } state_t;

  // ---------------- input synchronizers and edge detect ----------------
  logic [SYNC_STAGES-1:0] cs_sync, dclk_sync, din_sync;
  logic                   dclk_prev;
  logic                   cs_s, dclk_s, din_s, rise, fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;  // reads as deselected so reset lands cleanly in IDLE
      dclk_sync <= '0;
      din_sync  <= '0;
      dclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], adc_dclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], adc_din};
      dclk_prev <= dclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = dclk_s & ~dclk_prev;
  assign fall   = ~dclk_s & dclk_prev;

  // ---------------- FSM state and datapath registers ----------------
  state_t            state, state_n;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n, bitcnt_inc, last_cnt;
  logic [6:0]        shreg, shreg_n;      // first 7 control bits, S in the MSB at the end
  logic [DATA_W-1:0] sample, sample_n;    // result shift register, MSB goes out first
  logic              mode8, mode8_n;
  logic              dout_r, dout_n;
  logic              busy_r, busy_n;
  logic              done_n;
  logic [7:0]        last_ctrl_n, ctrl_byte;
  logic [DATA_W-1:0] chan_val;
  logic              abort;

  assign bitcnt_inc = bitcnt + CNT_W'(1);
  assign last_cnt   = mode8 ? CNT_W'(8) : CNT_W'(DATA_W);
  assign ctrl_byte  = {shreg, din_s};

  // Channel decode on A2..A0 of the byte being completed.
  always_comb begin
    chan_val = '0;
    if (ctrl_byte[6:4] == 3'b101)      chan_val = x_value;
    else if (ctrl_byte[6:4] == 3'b001) chan_val = y_value;
  end

  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    sample_n    = sample;
    mode8_n     = mode8;
    dout_n      = dout_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    last_ctrl_n = last_ctrl;
    abort       = 1'b0;

    if (cs_s) begin
      // Deselect beats any dclk edge seen in the same clk.
      state_n = IDLE;
      dout_n  = 1'b0;
      busy_n  = 1'b0;
      abort   = (state == CMD) || (state == WAITB) || (state == BUSY) || (state == DATA);
    end else begin
      case (state)
        IDLE: begin
          dout_n  = 1'b0;
          busy_n  = 1'b0;
          state_n = HUNT;
        end
        HUNT, TAIL: begin
          dout_n = 1'b0;
          if (rise && din_s) begin
            bitcnt_n = CNT_W'(1);
            shreg_n  = 7'd1;
            state_n  = CMD;
          end
        end
        CMD: begin
          if (rise) begin
            if (bitcnt == CNT_W'(7)) begin
              last_ctrl_n = ctrl_byte;
              mode8_n     = ctrl_byte[3];
              sample_n    = ctrl_byte[3] ? (chan_val & ~LOW_BITS) : chan_val;
              state_n     = WAITB;
            end else begin
              shreg_n  = {shreg[5:0], din_s};
              bitcnt_n = bitcnt_inc;
            end
          end
        end
        WAITB: begin
          if (fall) begin
            busy_n  = 1'b1;
            state_n = BUSY;
          end
        end
        BUSY: begin
          if (fall) begin
            busy_n   = 1'b0;
            dout_n   = sample[DATA_W-1];
            sample_n = sample << 1;
            bitcnt_n = CNT_W'(1);   // counts result bits already driven
            state_n  = DATA;
          end
        end
        DATA: begin
          if (fall) begin
            if (bitcnt == last_cnt) begin
              dout_n  = 1'b0;
              state_n = TAIL;
            end else begin
              dout_n   = sample[DATA_W-1];
              sample_n = sample << 1;
              bitcnt_n = bitcnt_inc;
              done_n   = (bitcnt_inc == last_cnt);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      sample    <= '0;
      mode8     <= 1'b0;
      dout_r    <= 1'b0;
      busy_r    <= 1'b0;
      conv_done <= 1'b0;
      last_ctrl <= 8'h00;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      sample    <= sample_n;
      mode8     <= mode8_n;
      dout_r    <= dout_n;
      busy_r    <= busy_n;
      conv_done <= done_n;
      last_ctrl <= last_ctrl_n;
    end
  end

  assign adc_dout = dout_r;
  assign adc_busy = busy_r;

  // Pen interrupt only while no conversion is in progress and PD0 allows it.
  assign adc_penirq_n = ((state == IDLE) || (state == HUNT) || (state == TAIL)) && !last_ctrl[0]
                        ? ~pen_down : 1'b1;

`ifdef LT24_ADC_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else if (abort) begin
      frame_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  logic abort_unused;
  assign abort_unused = abort;
`endif

endmodule

// File: tb/tb_lt24_touch_adc_responder.sv
module tb_lt24_touch_adc_responder;
  localparam int DATA_W      = 12;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;   // dclk half period in clk cycles

  logic              clk = 1'b0;
  logic              reset;
  logic              adc_cs_n, adc_dclk, adc_din;
  logic              adc_dout, adc_busy, adc_penirq_n;
  logic              pen_down;
  logic [DATA_W-1:0] x_value, y_value;
  logic              conv_done;
  logic [7:0]        last_ctrl;
`ifdef LT24_ADC_ERR_EN
  logic              frame_err;
  logic [7:0]        err_count;
`endif

  lt24_touch_adc_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .adc_cs_n     (adc_cs_n),
    .adc_dclk     (adc_dclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .adc_busy     (adc_busy),
    .adc_penirq_n (adc_penirq_n),
    .pen_down     (pen_down),
    .x_value      (x_value),
    .y_value      (y_value),
    .conv_done    (conv_done),
    .last_ctrl    (last_ctrl)
`ifdef LT24_ADC_ERR_EN
    ,
    .frame_err    (frame_err),
    .err_count    (err_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic [7:0] model_last_ctrl = 8'h00;
  logic smp_dout, smp_busy, smp_pen;

  always @(negedge clk) if (conv_done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value read back by the master, right-justified.
  function automatic logic [DATA_W-1:0] model(input logic [7:0] c,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] v;
    v = '0;
    if (c[6:4] == 3'b101)      v = x;
    else if (c[6:4] == 3'b001) v = y;
    if (c[3]) v = v >> (DATA_W - 8);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // One dclk period; outputs are sampled just before the rising edge, as the master does.
  task automatic dclk_cycle(input logic d);
    adc_din = d;
    repeat (HALF) @(negedge clk);
    smp_dout = adc_dout;
    smp_busy = adc_busy;
    smp_pen  = adc_penirq_n;
    adc_dclk = 1'b1;
    repeat (HALF) @(negedge clk);
    adc_dclk = 1'b0;
  endtask

  task automatic end_frame();
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
    repeat (HALF) @(negedge clk);
    check_val("idle_dout", adc_dout, 1'b0);
    check_val("idle_busy", adc_busy, 1'b0);
  endtask

  // Full 24-dclk conversion; adc_cs_n must already be low.
  task automatic do_conv(input logic [7:0] c);
    int nb;
    int d0;
    logic [DATA_W-1:0] got;
    logic pre_bad, tail_bad;
    logic exp_pen;
    exp_q.push_back(model(c, x_value, y_value));
    nb       = c[3] ? 8 : DATA_W;
    d0       = done_cnt;
    got      = '0;
    pre_bad  = 1'b0;
    tail_bad = 1'b0;
    exp_pen  = model_last_ctrl[0] ? 1'b1 : ~pen_down;
    for (int k = 1; k <= 24; k++) begin
      dclk_cycle((k <= 8) ? c[8-k] : 1'b0);
      if (k == 1)  check_val("penirq_waiting", smp_pen, exp_pen);
      if (k <= 8)  pre_bad = pre_bad | smp_busy | smp_dout;
      if (k == 9)  begin
        check_val("busy_after_byte", smp_busy, 1'b1);
        check_val("penirq_in_busy", smp_pen, 1'b1);
      end
      if (k == 10) begin
        check_val("busy_drop", smp_busy, 1'b0);
        check_val("penirq_in_data", smp_pen, 1'b1);
      end
      if (k >= 10 && k < 10 + nb) got = {got[DATA_W-2:0], smp_dout};
      if (k >= 10 + nb) tail_bad = tail_bad | smp_dout;
      // Sample must be frozen once latched.
      if (k == 12) begin
        x_value = ~x_value;
        y_value = ~y_value;
      end
    end
    check_val("pre_result_quiet", pre_bad, 1'b0);
    if (exp_q.size() == 0) check_val("queue_underflow", 1, 0);
    else check_val($sformatf("result_%02h", c), got, exp_q.pop_front());
    check_val("tail_dout", tail_bad, 1'b0);
    check_val("conv_done_once", done_cnt - d0, 1);
    check_val("last_ctrl", last_ctrl, c);
    model_last_ctrl = c;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] c;
    int d0;
    reset = 1'b1; adc_cs_n = 1'b1; adc_dclk = 1'b0; adc_din = 1'b0;
    pen_down = 1'b0; x_value = '0; y_value = '0;
    repeat (3) @(negedge clk);
    check_val("rst_dout", adc_dout, 1'b0);
    check_val("rst_busy", adc_busy, 1'b0);
    check_val("rst_penirq", adc_penirq_n, 1'b1);
    check_val("rst_last_ctrl", last_ctrl, 8'h00);
    check_val("rst_conv_done", conv_done, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // X, 12-bit
    x_value = 12'hA5C; y_value = 12'h123;
    adc_cs_n = 1'b0; do_conv(8'hD0); end_frame();

    // Y, 8-bit
    y_value = 12'h3F1;
    adc_cs_n = 1'b0; do_conv(8'h98); end_frame();

    // unused channel returns zero
    x_value = 12'hFFF; y_value = 12'hFFF;
    adc_cs_n = 1'b0; do_conv(8'hA0); end_frame();

`ifdef LT24_ADC_ERR_EN
    check_val("err_count_clean", err_count, 8'd0);
    check_val("frame_err_clean", frame_err, 1'b0);
`endif

    // abort after 4 control bits
    d0 = done_cnt;
    adc_cs_n = 1'b0;
    for (int k = 0; k < 4; k++) dclk_cycle(k == 0 || k == 3);
    end_frame();
    check_val("abort_cmd_last_ctrl", last_ctrl, 8'hA0);
    check_val("abort_cmd_no_done", done_cnt - d0, 0);
`ifdef LT24_ADC_ERR_EN
    check_val("abort_cmd_err_count", err_count, 8'd1);
    check_val("abort_cmd_frame_err", frame_err, 1'b1);
`endif

    // abort in the middle of the result
    d0 = done_cnt;
    x_value = 12'h5A5;
    c = 8'hD0;
    adc_cs_n = 1'b0;
    for (int k = 1; k <= 14; k++) dclk_cycle((k <= 8) ? c[8-k] : 1'b0);
    end_frame();
    check_val("abort_data_last_ctrl", last_ctrl, 8'hD0);
    check_val("abort_data_no_done", done_cnt - d0, 0);
    model_last_ctrl = 8'hD0;

    // cs pulse with no start bit is not an error
    adc_cs_n = 1'b0;
    for (int k = 0; k < 3; k++) dclk_cycle(1'b0);
    end_frame();
`ifdef LT24_ADC_ERR_EN
    check_val("abort_hunt_err_count", err_count, 8'd2);
`endif

    // back-to-back conversions within one cs_n window
    x_value = 12'h7E1; y_value = 12'h0C3;
    adc_cs_n = 1'b0; do_conv(8'hD0); do_conv(8'h90); end_frame();

    // pen interrupt
    pen_down = 1'b1;
    repeat (4) @(negedge clk);
    check_val("penirq_idle_down", adc_penirq_n, 1'b0);
    adc_cs_n = 1'b0; do_conv(8'hD1); end_frame();
    check_val("penirq_pd0_masked", adc_penirq_n, 1'b1);
    adc_cs_n = 1'b0; do_conv(8'h98); end_frame();
    check_val("penirq_pd0_clear", adc_penirq_n, 1'b0);
    pen_down = 1'b0;
    repeat (2) @(negedge clk);
    check_val("penirq_idle_up", adc_penirq_n, 1'b1);

    // randomized conversions, some back-to-back
    for (int i = 0; i < 8; i++) begin
      x_value  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      y_value  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      pen_down = 1'($urandom_range(0, 1));
      c        = 8'h80 | 8'($urandom_range(0, 127));
      adc_cs_n = 1'b0;
      do_conv(c);
      if ($urandom_range(0, 1) == 1) begin
        c = 8'h80 | 8'($urandom_range(0, 127));
        do_conv(c);
      end
      end_frame();
    end
    pen_down = 1'b0;

    // asynchronous reset in the middle of the result
    x_value = 12'hA5C;
    c = 8'hD0;
    adc_cs_n = 1'b0;
    for (int k = 1; k <= 9; k++) dclk_cycle((k <= 8) ? c[8-k] : 1'b0);
    repeat (HALF) @(negedge clk);
    check_val("pre_reset_msb", adc_dout, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_val("midrst_dout", adc_dout, 1'b0);
    check_val("midrst_busy", adc_busy, 1'b0);
    check_val("midrst_last_ctrl", last_ctrl, 8'h00);
    check_val("midrst_penirq", adc_penirq_n, 1'b1);
`ifdef LT24_ADC_ERR_EN
    check_val("midrst_err_count", err_count, 8'd0);
`endif
    adc_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
